sbit_rate_counter: RTL

SBIT_RATE_COUNTER -- requirements
Module: sbit_rate_counter

---
 rtl/sbit_rate_counter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sbit_rate_counter.sv
// sbit_rate_counter: measures per-VFAT S-bit hit rates over a programmable
// gate window. Each VFAT's S-bits are OR-reduced and masked into one hit bit.
// One saturating counter per VFAT counts the hit bits for gate_len clocks.
// Each completed window is latched into result registers, which rd_addr selects.
// Optional feature, enabled by defining SBIT_RATE_TOTAL_EN: a 25th counter of
// cycles with any unmasked hit, readable at rd_addr = 24.
module sbit_rate_counter #(
  parameter int MXSBITS   = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [MXSBITS*24-1:0]   sbits,
  input  logic [23:0]             sbit_mask,
  input  logic [23:0]             gate_len,
  input  logic                    start,
  input  logic                    continuous,
  input  logic [4:0]              rd_addr,
  output logic [CNT_WIDTH-1:0]    rd_data,
  output logic                    busy,
  output logic                    valid,
  output logic [23:0]             overflow
);

  localparam int NVFAT = 24;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARM, COUNT, LATCH} state_t;

  state_t               state_q;
  logic [23:0]          win_q;
  logic [23:0]          len_q;
  logic                 busy_q;
  logic                 valid_q;

  logic [NVFAT-1:0]     hit_d;
  logic [NVFAT-1:0]     hit_q;

  logic [CNT_WIDTH-1:0] cnt_q [NVFAT];
  logic [NVFAT-1:0]     ovf_q;
  logic [CNT_WIDTH-1:0] res_q [NVFAT];
  logic [NVFAT-1:0]     res_ovf_q;

  logic [CNT_WIDTH-1:0] rd_data_d;
  logic [CNT_WIDTH-1:0] rd_data_q;

`ifdef SBIT_RATE_TOTAL_EN
  logic [CNT_WIDTH-1:0] tot_q;
  logic [CNT_WIDTH-1:0] tot_res_q;
`endif

  // Per-VFAT hit: any S-bit set and the VFAT not masked.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    hit_d = '0;
    for (int n = 0; n < NVFAT; n++) begin
      hit_d[n] = (|sbits[n*MXSBITS +: MXSBITS]) & ~sbit_mask[n];
    end
  end

  // Hit pipeline register: one cycle of latency between sbits and counting.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) hit_q <= '0;
    else       hit_q <= hit_d;
  end

  // Measurement sequencer with registered busy/valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      win_q   <= '0;
      len_q   <= 24'd1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ARM;
            busy_q  <= 1'b1;
          end
        end
        ARM: begin
          state_q <= COUNT;
          win_q   <= '0;
          // A zero length still yields a one-cycle window.
          len_q   <= (gate_len == 24'd0) ? 24'd1 : gate_len;
        end
        COUNT: begin
          if (win_q == len_q - 24'd1) state_q <= LATCH;
          else                        win_q   <= win_q + 24'd1;
        end
        LATCH: begin
          valid_q <= 1'b1;
          if (continuous) begin
            state_q <= ARM;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Working counters: cleared in ARM, saturating increments during COUNT.
  always_ff @(posedge clock) begin
    // NOTE: the counter arrays are reset explicitly because reset must leave every count readable as zero.
    if (reset || state_q == ARM) begin
      for (int n = 0; n < NVFAT; n++) cnt_q[n] <= '0;
      ovf_q <= '0;
    end else if (state_q == COUNT) begin
      for (int n = 0; n < NVFAT; n++) begin
        if (hit_q[n]) begin
          if (cnt_q[n] == CNT_MAX) ovf_q[n] <= 1'b1;
          else                     cnt_q[n] <= cnt_q[n] + 1'b1;
        end
      end
    end
  end

`ifdef SBIT_RATE_TOTAL_EN
  // Total counter: cycles with any unmasked hit, saturating like the others.
  always_ff @(posedge clock) begin
    if (reset || state_q == ARM) begin
      tot_q <= '0;
    end else if (state_q == COUNT && (|hit_q) && tot_q != CNT_MAX) begin
      tot_q <= tot_q + 1'b1;
    end
  end

  // Total result register, updated only in LATCH.
  always_ff @(posedge clock) begin
    if (reset)                 tot_res_q <= '0;
    else if (state_q == LATCH) tot_res_q <= tot_q;
  end
`endif

  // Result registers: hold the last completed window until the next LATCH.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int n = 0; n < NVFAT; n++) res_q[n] <= '0;
      res_ovf_q <= '0;
    end else if (state_q == LATCH) begin
      for (int n = 0; n < NVFAT; n++) res_q[n] <= cnt_q[n];
      res_ovf_q <= ovf_q;
    end
  end

  // Read mux: per-VFAT results, optional total at 24, zero elsewhere.
  always_comb begin
    rd_data_d = '0;
    if (rd_addr < 5'd24) begin
      rd_data_d = res_q[rd_addr];
    end
`ifdef SBIT_RATE_TOTAL_EN
    else if (rd_addr == 5'd24) begin
      rd_data_d = tot_res_q;
    end
`endif
  end

  // Registered read port: one cycle from rd_addr to rd_data.
  always_ff @(posedge clock) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data  = rd_data_q;
  assign busy     = busy_q;
  assign valid    = valid_q;
  assign overflow = res_ovf_q;

endmodule
